// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: sequences one multiply-accumulate pass over an external sample buffer per
// accepted input sample.
//   IDLE: accept a sample and write it to the circular buffer at wr_ptr.
//   MAC:  step through TAPS taps, one per cycle, accumulating through a shared external adder.
//   DONE: present the result until the consumer takes it, then advance wr_ptr.
// Ports:
//   clk, rst_n                                 clock, synchronous active-low reset
//   in_valid/in_ready/in_data                  sample handshake
//   buf_wr_en/buf_wr_addr/buf_wr_data          sample-buffer write
//   coef_addr/smp_addr                         tap read addresses (product returns same cycle)
//   product                                    coefficient*sample for the current addresses
//   add_a/add_b/add_sum                        shared external adder
//   out_valid/out_ready/out_data               result handshake
// Build option: define FIR_MAC_SAT_EN to saturate the accumulator on signed overflow;
// without it the accumulator wraps in two's complement.
module fir_mac_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 38,
  parameter int unsigned TAPS       = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         buf_wr_en,
  output logic        [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic        [DATA_WIDTH-1:0] buf_wr_data,
  output logic        [ADDR_WIDTH-1:0] coef_addr,
  output logic        [ADDR_WIDTH-1:0] smp_addr,
  input  logic signed [ACC_WIDTH-1:0]  product,
  output logic signed [ACC_WIDTH-1:0]  add_a,
  output logic signed [ACC_WIDTH-1:0]  add_b,
  input  logic signed [ACC_WIDTH-1:0]  add_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(TAPS - 1);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                       state_q, state_d;
  logic        [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic        [ADDR_WIDTH-1:0] tap_q, tap_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  out_data_q, out_data_d;
  logic signed [ACC_WIDTH-1:0]  acc_load;

`ifdef FIR_MAC_SAT_EN
  // Operands share a sign but the sum does not: clamp toward the operands' sign.
  logic ovf;
  always_comb begin
    ovf = (acc_q[ACC_WIDTH-1] == product[ACC_WIDTH-1]) &&
          (add_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    acc_load = add_sum;
    if (ovf) begin
      acc_load = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    acc_load = add_sum;
  end
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    in_ready    = 1'b0;
    buf_wr_en   = 1'b0;
    buf_wr_addr = wr_ptr_q;
    buf_wr_data = in_data;
    coef_addr   = '0;
    smp_addr    = '0;
    add_a       = '0;
    add_b       = '0;
    out_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_wr_en = 1'b1;
          state_d   = StMac;
          tap_d     = '0;
          acc_d     = '0;
        end
      end
      StMac: begin
        coef_addr = tap_q;
        // Newest sample sits at wr_ptr; older ones lie behind it, wrapping modulo TAPS.
        if (tap_q > wr_ptr_q) begin
          smp_addr = wr_ptr_q + ADDR_WIDTH'(TAPS - 32'(tap_q));
        end else begin
          smp_addr = wr_ptr_q - tap_q;
        end
        add_a = acc_q;
        add_b = product;
        acc_d = acc_load;
        tap_d = tap_q + 1'b1;
        if (tap_q == LastIdx) begin
          tap_d      = '0;
          out_data_d = acc_load;
          state_d    = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Handshake outputs stay quiet for the whole reset cycle, whatever state we were in.
    if (!rst_n) begin
      in_ready  = 1'b0;
      buf_wr_en = 1'b0;
      out_valid = 1'b0;
    end
  end

  assign out_data = out_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      tap_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      tap_q      <= tap_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: a TAPS=4 instance with a modelled buffer, coefficient ROM,
// multiplier and adder, plus an ACC_WIDTH=8 instance fed from a product table for overflow.
module tb_fir_mac_sequencer;

  localparam int Taps = 4;
`ifdef FIR_MAC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               in_valid, in_ready, buf_wr_en, out_valid, out_ready;
  logic signed [15:0] in_data;
  logic        [1:0]  buf_wr_addr, coef_addr, smp_addr;
  logic        [15:0] buf_wr_data;
  logic signed [37:0] product, add_a, add_b, add_sum, out_data;

  logic              in_valid2, in_ready2, buf_wr_en2, out_valid2, out_ready2;
  logic signed [7:0] in_data2, product2, add_a2, add_b2, add_sum2, out_data2;
  logic        [1:0] buf_wr_addr2, coef_addr2, smp_addr2;
  logic        [7:0] buf_wr_data2;

  logic signed [15:0] mem  [Taps];
  logic signed [15:0] coef [Taps];
  logic signed [15:0] mbuf [Taps];
  logic signed [7:0]  ptab [Taps];
  int mptr;
  int n_cmp = 0;
  int n_fail = 0;

  fir_mac_sequencer #(.DATA_WIDTH(16), .ACC_WIDTH(38), .TAPS(4), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .coef_addr(coef_addr), .smp_addr(smp_addr), .product(product),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  fir_mac_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(8), .TAPS(4), .ADDR_WIDTH(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .buf_wr_en(buf_wr_en2), .buf_wr_addr(buf_wr_addr2), .buf_wr_data(buf_wr_data2),
    .coef_addr(coef_addr2), .smp_addr(smp_addr2), .product(product2),
    .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
  );

  // Environment: buffer RAM, coefficient ROM, multiplier, adder.
  always @(posedge clk) if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
  assign product  = 38'(coef[coef_addr]) * 38'(mem[smp_addr]);
  assign add_sum  = add_a + add_b;
  assign product2 = ptab[coef_addr2];
  assign add_sum2 = add_a2 + add_b2;

  // Reference: y = sum_k coef[k] * x[newest - k], over the circular buffer.
  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < Taps; k++) s += longint'(coef[k]) * longint'(mbuf[(mptr - k + Taps) % Taps]);
    return s;
  endfunction

  // Reference for the narrow instance: running 8-bit accumulation, clamped or wrapped per add.
  function automatic int model_acc8(input bit sat);
    int acc = 0;
    for (int k = 0; k < Taps; k++) begin
      acc = acc + int'(ptab[k]);
      if (sat) begin
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
      end else begin
        acc = int'($signed(8'(acc)));
      end
    end
    return acc;
  endfunction

  // Offer one sample in IDLE and wait (bounded) for out_valid; returns at the first DONE cycle.
  task automatic run_sample(input logic signed [15:0] d, output int lat, output logic [1:0] wa,
                            output bit wen, output bit stray, output logic [7:0] cseq,
                            output logic [7:0] sseq);
    in_valid = 1'b1; in_data = d; #1;
    wen = buf_wr_en; wa = buf_wr_addr;
    @(posedge clk); #1;
    mbuf[mptr] = d;
    lat = 0; stray = 1'b0; cseq = '0; sseq = '0;
    for (int c = 1; c <= 20; c++) begin
      in_valid = 1'($urandom); in_data = 16'($urandom); #1;
      if (buf_wr_en || in_ready) stray = 1'b1;
      if (c <= Taps) begin
        cseq[2*(c-1) +: 2] = coef_addr;
        sseq[2*(c-1) +: 2] = smp_addr;
      end
      if (out_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Let the DONE handshake (out_ready already high) complete.
  task automatic take_out();
    @(posedge clk); #1;
    mptr = (mptr + 1) % Taps;
  endtask

  task automatic test_reset();
    int lat; logic [1:0] wa; bit wen, stray; logic [7:0] cs, ss;
    out_ready = 1'b0;
    run_sample(16'($urandom), lat, wa, wen, stray, cs, ss);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++;
      $display("FAIL reset_pre_done: out_valid=%b want 1", out_valid); end
    rst_n = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++;
        $display("FAIL reset_hold: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid); end
      @(posedge clk); #1;
      n_cmp++; if (out_data !== 38'sd0) begin n_fail++;
        $display("FAIL reset_out_data: got %0d want 0", out_data); end
    end
    rst_n = 1'b1; out_ready = 1'b1; mptr = 0; #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_impulse();
    logic signed [15:0] din [4];
    longint exp_y [4];
    int lat; logic [1:0] wa; bit wen, stray; logic [7:0] cs, ss;
    din = '{16'sd5, 16'sd0, 16'sd0, 16'sd0};
    exp_y = '{5, 10, 15, 20};
    coef = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    for (int i = 0; i < Taps; i++) begin
      run_sample(din[i], lat, wa, wen, stray, cs, ss);
      n_cmp++; if (lat !== 5) begin n_fail++;
        $display("FAIL impulse_latency[%0d]: got %0d want 5", i, lat); end
      n_cmp++; if (out_data !== 38'(exp_y[i]) || out_data !== 38'(model_out())) begin n_fail++;
        $display("FAIL impulse_data[%0d]: got %0d want %0d", i, out_data, exp_y[i]); end
      n_cmp++; if (wen !== 1'b1 || wa !== 2'(i) || stray !== 1'b0) begin n_fail++;
        $display("FAIL impulse_write[%0d]: en=%b addr=%0d stray=%b want 1 %0d 0", i, wen, wa, stray, i); end
      take_out();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
        $display("FAIL impulse_ready[%0d]: in_ready=%b want 1", i, in_ready); end
    end
  endtask

  task automatic test_wrap();
    int lat; logic [1:0] wa; bit wen, stray; logic [7:0] cs, ss;
    run_sample(16'($urandom), lat, wa, wen, stray, cs, ss);
    n_cmp++; if (wa !== 2'd0 || wen !== 1'b1) begin n_fail++;
      $display("FAIL wrap_wr_addr: got %0d en=%b want 0 1", wa, wen); end
    n_cmp++; if (ss !== {2'd1, 2'd2, 2'd3, 2'd0}) begin n_fail++;
      $display("FAIL wrap_smp_seq: got %h want %h", ss, {2'd1, 2'd2, 2'd3, 2'd0}); end
    n_cmp++; if (cs !== {2'd3, 2'd2, 2'd1, 2'd0}) begin n_fail++;
      $display("FAIL wrap_coef_seq: got %h want %h", cs, {2'd3, 2'd2, 2'd1, 2'd0}); end
    n_cmp++; if (out_data !== 38'(model_out())) begin n_fail++;
      $display("FAIL wrap_data: got %0d want %0d", out_data, model_out()); end
    take_out();
  endtask

  task automatic test_random();
    int lat; logic [1:0] wa; bit wen, stray; logic [7:0] cs, ss;
    for (int k = 0; k < Taps; k++) coef[k] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      run_sample(16'($urandom), lat, wa, wen, stray, cs, ss);
      n_cmp++; if (lat !== 5 || out_data !== 38'(model_out())) begin n_fail++;
        $display("FAIL random_data[%0d]: lat=%0d got %0d want 5 %0d", i, lat, out_data, model_out()); end
      n_cmp++; if (wa !== 2'(mptr) || stray !== 1'b0) begin n_fail++;
        $display("FAIL random_write[%0d]: addr=%0d stray=%b want %0d 0", i, wa, stray, mptr); end
      take_out();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [1:0] wa; bit wen, stray; logic [7:0] cs, ss;
    longint exp_y;
    out_ready = 1'b0;
    run_sample(16'($urandom), lat, wa, wen, stray, cs, ss);
    exp_y = model_out();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); in_data = 16'($urandom); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 38'(exp_y) || in_ready !== 1'b0 ||
          buf_wr_en !== 1'b0 || add_b !== 38'sd0 || coef_addr !== 2'd0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: valid=%b data=%0d rdy=%b wr=%b want 1 %0d 0 0",
                 i, out_valid, out_data, in_ready, buf_wr_en, exp_y);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    take_out();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 38'(exp_y)) begin n_fail++;
      $display("FAIL backpressure_release: rdy=%b valid=%b data=%0d want 1 0 %0d",
               in_ready, out_valid, out_data, exp_y); end
  endtask

  task automatic test_mac_reset();
    int lat; logic [1:0] wa; bit wen, stray; logic [7:0] cs, ss;
    bit seen = 1'b0;
    logic signed [15:0] d = 16'($urandom);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    mbuf[mptr] = d;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (coef_addr !== 2'd2) begin n_fail++;
      $display("FAIL macreset_tap: coef_addr=%0d want 2", coef_addr); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mptr = 0; #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL macreset_idle: rdy=%b valid=%b want 1 0", in_ready, out_valid); end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++;
      $display("FAIL macreset_no_valid: out_valid seen=%b want 0", seen); end
    run_sample(16'($urandom), lat, wa, wen, stray, cs, ss);
    n_cmp++; if (wa !== 2'd0 || out_data !== 38'(model_out())) begin n_fail++;
      $display("FAIL macreset_next: addr=%0d data=%0d want 0 %0d", wa, out_data, model_out()); end
    take_out();
  endtask

  task automatic test_overflow();
    logic signed [7:0] tabs [3][4];
    int lat;
    int fixed_exp [2];
    tabs[0] = '{8'sd100, 8'sd100, 8'sd0, 8'sd0};
    tabs[1] = '{-8'sd100, -8'sd100, 8'sd0, 8'sd0};
    for (int k = 0; k < Taps; k++) tabs[2][k] = 8'($signed(7'($urandom)));
    fixed_exp = Sat ? '{127, -128} : '{-56, 56};
    for (int t = 0; t < 3; t++) begin
      ptab = tabs[t];
      in_valid2 = 1'b1; in_data2 = 8'($urandom);
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        if (out_valid2) begin lat = c; break; end
        @(posedge clk); #1;
      end
      n_cmp++; if (lat !== 5 || out_data2 !== 8'(model_acc8(Sat))) begin n_fail++;
        $display("FAIL overflow_model[%0d]: lat=%0d got %0d want 5 %0d", t, lat, out_data2,
                 model_acc8(Sat)); end
      if (t < 2) begin
        n_cmp++; if (out_data2 !== 8'(fixed_exp[t])) begin n_fail++;
          $display("FAIL overflow_fixed[%0d]: got %0d want %0d", t, out_data2, fixed_exp[t]); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    for (int i = 0; i < Taps; i++) begin
      mem[i] = '0; mbuf[i] = '0; coef[i] = '0; ptab[i] = '0;
    end
    mptr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    test_impulse();
    test_wrap();
    test_random();
    test_backpressure();
    test_mac_reset();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: input sample width.
REQ-002 Parameter ACC_WIDTH, default 38: product, adder and accumulator width, signed.
REQ-003 Parameter TAPS, default 64: number of filter taps, range 2..2^ADDR_WIDTH.
REQ-004 Parameter ADDR_WIDTH, default 6: sample/coefficient address width.
REQ-005 The block SHALL have one clock, clk; reset rst_n SHALL be synchronous and active-low.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst_n, input, 1: synchronous active-low reset.
REQ-008 Port in_valid, input, 1; in_ready, output, 1; in_data, input, DATA_WIDTH, signed: sample handshake.
REQ-009 Port buf_wr_en, output, 1; buf_wr_addr, output, ADDR_WIDTH; buf_wr_data, output, DATA_WIDTH: sample-buffer write.
REQ-010 Port coef_addr, output, ADDR_WIDTH; smp_addr, output, ADDR_WIDTH: tap read addresses.
REQ-011 Port product, input, ACC_WIDTH, signed: coefficient*sample for the current addresses, valid in the same cycle.
REQ-012 Port add_a, output; add_b, output; add_sum, input; all ACC_WIDTH, signed: shared external adder.
REQ-013 Port out_valid, output, 1; out_ready, input, 1; out_data, output, ACC_WIDTH, signed: result handshake.

Function
REQ-014 FSM states SHALL be IDLE, MAC and DONE.
REQ-015 IDLE: in_ready=1; when in_valid=1, buf_wr_en=1, buf_wr_addr=wr_ptr, buf_wr_data=in_data (same cycle); next state MAC with tap=0, acc=0.
REQ-016 buf_wr_en SHALL be 0 in every cycle other than an accepted IDLE handshake.
REQ-017 MAC, tap k (0..TAPS-1): coef_addr=k, smp_addr=(wr_ptr-k) mod TAPS, add_a=acc, add_b=product; acc<=add_sum (after configured overflow handling).
REQ-018 MAC SHALL last exactly TAPS cycles; after tap TAPS-1 the state SHALL become DONE.
REQ-019 DONE: out_valid=1, out_data=acc, held stable until out_ready=1; on out_valid&&out_ready, wr_ptr<=(wr_ptr+1) mod TAPS and the state SHALL become IDLE.
REQ-020 wr_ptr SHALL wrap from TAPS-1 to 0; smp_addr SHALL wrap below 0 to TAPS-1 (non-power-of-2 TAPS included).
REQ-021 Latency: sample accepted at cycle T -> out_valid first high at T+TAPS+1; with out_ready=1, in_ready next high at T+TAPS+2.
REQ-022 in_ready SHALL be 0 in MAC and DONE; in_valid and in_data SHALL be ignored there.
REQ-023 Outside MAC, add_a, add_b, coef_addr and smp_addr SHALL be 0.
REQ-024 out_valid SHALL be 0 in IDLE and MAC; out_data SHALL hold the last result outside DONE.

Reset
REQ-025 rst_n=0 at a clock edge SHALL set state=IDLE, wr_ptr=0, tap=0, acc=0, out_data=0 and all valid/enable outputs to 0, in any state including mid-MAC or DONE.
REQ-026 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-027 External buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro FIR_MAC_SAT_EN defined: when add_a and add_b share a sign and add_sum differs, acc SHALL load the signed max (positive) or min (negative) of ACC_WIDTH.
REQ-029 Macro FIR_MAC_SAT_EN undefined: acc SHALL load add_sum unmodified (two's-complement wrap).

Verification (TAPS=4, ADDR_WIDTH=2; bench models adder and product=coef[coef_addr]*buf[smp_addr])
REQ-030 Reset: rst_n low 2 cycles from DONE -> out_valid=0, out_data=0, in_ready=0 during reset, 1 in the next cycle.
REQ-031 Impulse: buffer zero, coef {1,2,3,4}, inputs 5,0,0,0 -> out_data 5,10,15,20, each out_valid at T+5.
REQ-032 Wrap: fifth accepted sample -> buf_wr_addr=0, smp_addr sequence 0,3,2,1, coef_addr 0,1,2,3.
REQ-033 Backpressure: out_ready low 10 cycles in DONE -> out_valid=1 and out_data stable, in_ready=0, in_valid pulses produce no buf_wr_en.
REQ-034 Overflow, ACC_WIDTH=8, products 100,100,0,0 -> out_data=127 with FIR_MAC_SAT_EN, -56 without.
REQ-035 Reset during MAC tap 2 -> IDLE next cycle, out_valid never asserted, next sample written at address 0.
